// File: rtl/res_chk_pkg.sv
// Shared types and defaults for the result checker.
package res_chk_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEF   = 32;
    localparam int CNT_W_DEF   = 16;
    localparam int N_TESTS_DEF = 1000;
    localparam logic [CNT_W_DEF-1:0] SAT_LIMIT_DEF = {CNT_W_DEF{1'b1}};
endpackage

// File: rtl/res_chk_if.sv
// Sample/result bus between the monitor stage and the result checker.
interface res_chk_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) ();
    logic             i_start;
    logic             i_valid;
    logic [WIDTH-1:0] i_mon_o;
    logic [WIDTH-1:0] i_dtm_o;
    logic             o_busy;
    logic             o_done;
    logic             o_pass;
    logic [CNT_W-1:0] o_test_cnt;
    logic [CNT_W-1:0] o_err_cnt;
    logic             o_err_pulse;
    logic [CNT_W-1:0] o_first_idx;
    logic [WIDTH-1:0] o_first_mon;
    logic [WIDTH-1:0] o_first_dtm;

    modport slave (
        input  i_start, i_valid, i_mon_o, i_dtm_o,
        output o_busy, o_done, o_pass, o_test_cnt, o_err_cnt, o_err_pulse,
               o_first_idx, o_first_mon, o_first_dtm
    );

    modport master (
        output i_start, i_valid, i_mon_o, i_dtm_o,
        input  o_busy, o_done, o_pass, o_test_cnt, o_err_cnt, o_err_pulse,
               o_first_idx, o_first_mon, o_first_dtm
    );
endinterface

// File: rtl/res_chk_sat_cnt.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module res_chk_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && cnt_q != SAT)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/res_chk.sv
// Scoreboard endpoint: compares golden vs DUT results over a run of N_TESTS samples.
// Define RES_CHK_STOP_ON_ERR_EN to end a run at its first mismatch.
module res_chk
    import res_chk_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int N_TESTS = N_TESTS_DEF
) (
    input  logic     clk,
    input  logic     reset,
    res_chk_if.slave bus
);
`ifdef RES_CHK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TESTS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] test_cnt_q, test_cnt_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic [WIDTH-1:0] first_mon_q, first_mon_d;
    logic [WIDTH-1:0] first_dtm_q, first_dtm_d;
    logic             first_seen_q, first_seen_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_clr, err_inc, mismatch;
    logic [CNT_W-1:0] err_cnt;

    always_comb begin
        state_d      = state_q;
        test_cnt_d   = test_cnt_q;
        first_idx_d  = first_idx_q;
        first_mon_d  = first_mon_q;
        first_dtm_d  = first_dtm_q;
        first_seen_d = first_seen_q;
        err_pulse_d  = 1'b0;
        err_clr      = 1'b0;
        err_inc      = 1'b0;
        mismatch     = (bus.i_mon_o != bus.i_dtm_o);

        case (state_q)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    state_d      = RUN;
                    test_cnt_d   = '0;
                    first_idx_d  = '0;
                    first_mon_d  = '0;
                    first_dtm_d  = '0;
                    first_seen_d = 1'b0;
                    err_clr      = 1'b1;
                end
            end
            RUN: begin
                if (bus.i_valid) begin
                    test_cnt_d = test_cnt_q + CNT_W'(1);
                    if (mismatch) begin
                        err_inc     = 1'b1;
                        err_pulse_d = 1'b1;
                        // first_seen, not err_cnt==0, so capture stays correct past saturation
                        if (!first_seen_q) begin
                            first_seen_d = 1'b1;
                            first_idx_d  = test_cnt_q;
                            first_mon_d  = bus.i_mon_o;
                            first_dtm_d  = bus.i_dtm_o;
                        end
                    end
                    if (test_cnt_q == LAST_IDX || (STOP_ON_ERR && mismatch))
                        state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            test_cnt_q   <= '0;
            first_idx_q  <= '0;
            first_mon_q  <= '0;
            first_dtm_q  <= '0;
            first_seen_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            test_cnt_q   <= test_cnt_d;
            first_idx_q  <= first_idx_d;
            first_mon_q  <= first_mon_d;
            first_dtm_q  <= first_dtm_d;
            first_seen_q <= first_seen_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    res_chk_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (err_clr),
        .inc   (err_inc),
        .cnt   (err_cnt)
    );

    assign bus.o_busy      = (state_q == RUN);
    assign bus.o_done      = (state_q == DONE);
    assign bus.o_pass      = (state_q == DONE) && (err_cnt == '0);
    assign bus.o_test_cnt  = test_cnt_q;
    assign bus.o_err_cnt   = err_cnt;
    assign bus.o_err_pulse = err_pulse_q;
    assign bus.o_first_idx = first_idx_q;
    assign bus.o_first_mon = first_mon_q;
    assign bus.o_first_dtm = first_dtm_q;
endmodule
